// File: rtl/fifo_pkg.sv
// Shared defaults and elaboration helpers for the parameterised synchronous FIFO.
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 8;
  localparam int unsigned DEF_INDEX_WIDTH = 4;

  // Pointer width: one extra wrap bit above the storage index.
  function automatic int unsigned ptr_width(input int unsigned index_width);
    return index_width + 1;
  endfunction

  // almost_full threshold must be 1..DEPTH, almost_empty threshold 0..DEPTH-1.
  function automatic bit thresholds_ok(input int unsigned index_width,
                                       input int unsigned af_thr,
                                       input int unsigned ae_thr);
    int unsigned depth;
    depth = 32'd1 << index_width;
    return (af_thr >= 1) && (af_thr <= depth) && (ae_thr <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned INDEX_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [INDEX_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic [INDEX_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]  rdata
);

  localparam int unsigned DEPTH = 1 << INDEX_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param_sync.sv
// Parameterised synchronous FIFO with occupancy count, flush, sticky error flags
// and a choice of registered or first-word-fall-through read.
module fifo_param_sync
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH             = DEF_DATA_WIDTH,
  parameter int unsigned INDEX_WIDTH            = DEF_INDEX_WIDTH,
  parameter int unsigned ALMOST_FULL_THRESHOLD  = 12,
  parameter int unsigned ALMOST_EMPTY_THRESHOLD = 4,
  parameter bit          FWFT                   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [INDEX_WIDTH:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 1 << INDEX_WIDTH;
  localparam int unsigned PTR_W = ptr_width(INDEX_WIDTH);

  typedef logic [PTR_W-1:0] ptr_t;

  if (INDEX_WIDTH < 1) begin : g_bad_index
    $error("fifo_param_sync: INDEX_WIDTH must be at least 1");
  end
  if (!thresholds_ok(INDEX_WIDTH, ALMOST_FULL_THRESHOLD, ALMOST_EMPTY_THRESHOLD)) begin : g_bad_thr
    $error("fifo_param_sync: almost_full/almost_empty threshold out of range");
  end

  ptr_t                  wr_ptr;
  ptr_t                  rd_ptr;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  ovf_event;
  logic                  udf_event;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Status is derived purely from the registered pointers.
  assign count        = wr_ptr - rd_ptr;
  assign full         = (count == PTR_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= PTR_W'(ALMOST_FULL_THRESHOLD));
  assign almost_empty = (count <= PTR_W'(ALMOST_EMPTY_THRESHOLD));

  // A write into a full FIFO is still taken when a read frees a slot on the same edge.
  assign rd_accept = !flush && rd_en && !empty;
  assign wr_accept = !flush && wr_en && (!full || rd_accept);
  assign ovf_event = wr_en && full && !rd_en;
  assign udf_event = rd_en && empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_accept) rd_ptr <= rd_ptr + PTR_W'(1);
      // A new error event wins over a simultaneous clear.
      overflow  <= ovf_event || (overflow  && !clr_err);
      underflow <= udf_event || (underflow && !clr_err);
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_accept),
    .waddr(wr_ptr[INDEX_WIDTH-1:0]),
    .wdata(wr_data),
    .raddr(rd_ptr[INDEX_WIDTH-1:0]),
    .rdata(mem_rdata)
  );

  if (FWFT) begin : g_fwft
    // Head word is shown directly; masked to zero while empty so reset reads as 0.
    assign rd_data  = empty ? '0 : mem_rdata;
    assign rd_valid = !empty;
  end else begin : g_reg_read
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else if (flush) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_accept;
        if (rd_accept) rd_data <= mem_rdata;
      end
    end
  end

endmodule
